// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multi-cycle CPU: default address/instruction
// widths used by fetch, decode and the CPU top, the default prefetch depth,
// and the fetch FSM state encoding.
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int CPU_ADDR_W  = 8;
    localparam int CPU_INST_W  = 32;
    localparam int FETCH_DEPTH = 4;

    // Fetch sequencer states.
    //   IDLE    : no request outstanding
    //   WAIT    : imem_req high, awaiting ack; the response will be kept
    //   DISCARD : request outstanding, but its response is dead (redirected)
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous prefetch FIFO, DEPTH entries of W bits, no fall-through.
// Flush has priority over push and pop. Pop on empty and push on full are
// ignored. The storage is reset so the head reads zero out of reset.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   push, wdata  write an entry at the tail
//   pop          remove the head entry
//   flush        discard all entries
//   rdata        head entry (meaningful when count != 0)
//   count        number of valid entries, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 40
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    input  logic                       flush,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && (count_q != DEPTH_C);
        do_pop   = pop && (count_q != '0);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule : fetch_fifo

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Owns the fetch PC, issues requests to instruction
// memory over req/ack, buffers returned words with their PC in fetch_fifo and
// hands them to the sequencer over a valid/ready port. A redirect flushes the
// FIFO and any in-flight response and refetches from redirect_pc.
//
// Handshakes:
//   imem: a transfer happens in a cycle with imem_req && imem_ack; imem_rdata
//         is valid in that same cycle. Once raised, imem_req and imem_addr
//         hold until the ack (never retracted).
//   inst: a transfer happens in a cycle with inst_valid && inst_ready;
//         inst_data/inst_pc hold while inst_valid && !inst_ready.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req, imem_addr        request to instruction memory
//   imem_ack, imem_rdata       accept + same-cycle read data
//   inst_valid/data/pc, ready  FIFO head to the sequencer
//   redirect_valid/pc          taken branch: flush and refetch
// ---------------------------------------------------------------------------
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int INST_W = CPU_INST_W,
    parameter int DEPTH  = FETCH_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    // Address of the request currently (or next) on the bus.
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_flush;
    logic [INST_W+ADDR_W-1:0] fifo_rdata;
    logic [CW-1:0]            fifo_count;
    logic                     pop_eff;
    logic [CW-1:0]            count_after;
    logic [ADDR_W-1:0]        addr_inc;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        fifo_pop   = inst_ready;
        pop_eff    = inst_ready && (fifo_count != '0);
        // Occupancy after this cycle's push (if any) and pop.
        count_after = fifo_count + CW'(1) - CW'(pop_eff);
        addr_inc    = addr_q + ADDR_W'(1);

        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    fifo_flush = 1'b1;
                    fetch_pc_d = redirect_pc;
                    addr_d     = redirect_pc;
                    state_d    = WAIT;
                end else if (fifo_count < DEPTH_C) begin
                    addr_d  = fetch_pc_q;
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (redirect_valid) begin
                    fifo_flush = 1'b1;
                    fetch_pc_d = redirect_pc;
                    if (imem_ack) begin
                        // Acked data is dropped; the new stream starts now.
                        addr_d  = redirect_pc;
                        state_d = WAIT;
                    end else begin
                        // Request must stay up; its response is dead.
                        state_d = DISCARD;
                    end
                end else if (imem_ack) begin
                    fifo_push  = 1'b1;
                    fetch_pc_d = addr_inc;
                    if (count_after < DEPTH_C) begin
                        addr_d = addr_inc;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            DISCARD: begin
                // FIFO is already empty here; flushing again keeps the
                // redirect-beats-pop rule uniform across states.
                if (redirect_valid) begin
                    fifo_flush = 1'b1;
                    fetch_pc_d = redirect_pc;
                end
                if (imem_ack) begin
                    // Dead response retires; start the live stream, taking a
                    // same-cycle redirect target directly.
                    addr_d  = redirect_valid ? redirect_pc : fetch_pc_q;
                    state_d = WAIT;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (INST_W + ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata ({imem_rdata, addr_q}),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    assign imem_req   = (state_q == WAIT) || (state_q == DISCARD);
    assign imem_addr  = addr_q;
    assign inst_valid = (fifo_count != '0);
    assign inst_data  = fifo_rdata[INST_W+ADDR_W-1:ADDR_W];
    assign inst_pc    = fifo_rdata[ADDR_W-1:0];

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed scenarios plus a randomized phase. Expected instruction stream is
// modelled as "sequential PCs from the last reset/redirect target", with data
// taken from the memory contents function; a monitor pops and compares on
// every accepted instruction.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int AW = 8;
  localparam int IW = 32;

  logic          clk;
  logic          rst_n;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic          inst_valid;
  logic [IW-1:0] inst_data;
  logic [AW-1:0] inst_pc;
  logic          inst_ready;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;

  int n_checks = 0;
  int n_pass   = 0;

  // expected {pc, data} stream
  logic [AW+IW-1:0] exp_q[$];
  logic [AW-1:0]    model_pc;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- memory contents ----------------
  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return {8'hC3 ^ a, a, ~a, a + 8'h11};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void model_restart(input logic [AW-1:0] pc);
    exp_q.delete();
    model_pc = pc;
  endfunction

  function automatic void model_refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back({model_pc, mem_word(model_pc)});
      model_pc = model_pc + 8'd1;
    end
  endfunction

  // ---------------- monitor ----------------
  logic          prev_ok;
  logic          prev_req, prev_ack, prev_valid, prev_ready, prev_redirect;
  logic [AW-1:0] prev_addr, prev_pc;
  logic [IW-1:0] prev_data;
  int            stall_cnt;

  initial begin
    prev_ok   = 1'b0;
    stall_cnt = 0;
    model_restart('0);
    model_refill();
  end

  always @(negedge clk) begin
    logic [AW+IW-1:0] e;
    if (!rst_n) begin
      model_restart('0);
      model_refill();
      prev_ok   = 1'b0;
      stall_cnt = 0;
    end else begin
      if (prev_ok) begin
        if (prev_req && !prev_ack)
          check("req_hold", {imem_req, imem_addr}, {1'b1, prev_addr});
        if (prev_redirect)
          check("flush_invalid", {63'd0, inst_valid}, 64'd0);
        else if (prev_valid && !prev_ready)
          check("head_hold", {inst_valid, inst_pc, inst_data}, {1'b1, prev_pc, prev_data});
      end
      if (redirect_valid) begin
        model_restart(redirect_pc);
        model_refill();
      end else if (inst_valid && inst_ready) begin
        e = exp_q.pop_front();
        check("stream", {inst_pc, inst_data}, e);
        model_refill();
      end
      if (inst_ready && !inst_valid) stall_cnt++;
      else stall_cnt = 0;
      if (stall_cnt == 60) begin
        check("progress", 64'(stall_cnt), 64'd0);
        stall_cnt = 0;
      end
      prev_ok       = 1'b1;
      prev_req      = imem_req;
      prev_ack      = imem_ack;
      prev_addr     = imem_addr;
      prev_valid    = inst_valid;
      prev_ready    = inst_ready;
      prev_redirect = redirect_valid;
      prev_pc       = inst_pc;
      prev_data     = inst_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string name);
    check(name, {imem_req, imem_addr, inst_valid, inst_pc, inst_data},
          {1'b0, 8'd0, 1'b0, 8'd0, 32'd0});
  endtask

  // Reset, then release; returns at posedge+1 of the first cycle after release.
  task automatic do_reset(input logic a, input logic r);
    rst_n          = 1'b0;
    imem_ack       = a;
    inst_ready     = r;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (3) step();
    check_zero_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("first_req", {imem_req, imem_addr}, {1'b1, 8'd0});
  endtask

  task automatic wait_addr(input logic [AW-1:0] a, input string name);
    int n = 0;
    while (!(imem_req && imem_addr == a) && n < 40) begin
      step();
      n++;
    end
    check(name, {imem_req, imem_addr}, {1'b1, a});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pushes;
    rst_n          = 1'b0;
    imem_ack       = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // 1) streaming: addr 0,1,2..., inst_pc one cycle behind
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("stream_addr", {imem_req, imem_addr}, {1'b1, 8'(i)});
      if (i > 0) check("stream_pc", {inst_valid, inst_pc}, {1'b1, 8'(i - 1)});
      step();
    end

    // 2) consumer stalled: exactly four fetches at 0..3, then resume at 4
    do_reset(1'b1, 1'b0);
    pushes = 0;
    for (int i = 0; i < 8; i++) begin
      if (imem_req) begin
        check("fill_addr", {56'd0, imem_addr}, 64'(pushes));
        pushes++;
      end
      step();
    end
    check("fill_count", 64'(pushes), 64'd4);
    check("full_idle", {imem_req, inst_valid, inst_pc}, {1'b0, 1'b1, 8'd0});
    inst_ready = 1'b1;
    wait_addr(8'd4, "resume_addr");
    repeat (6) step();

    // 3) ack delayed three cycles at address 5
    do_reset(1'b1, 1'b1);
    wait_addr(8'd5, "reach_5");
    for (int j = 0; j < 4; j++) begin
      check("delay_hold", {imem_req, imem_addr}, {1'b1, 8'd5});
      imem_ack = (j == 3);
      step();
    end
    check("after_delay", {imem_req, imem_addr}, {1'b1, 8'd6});
    repeat (4) step();

    // 4) redirect to 0x40 while waiting at 0x07 without ack
    do_reset(1'b1, 1'b1);
    wait_addr(8'd7, "reach_7");
    imem_ack       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    step();
    redirect_valid = 1'b0;
    check("discard_empty", {63'd0, inst_valid}, 64'd0);
    check("discard_hold", {imem_req, imem_addr}, {1'b1, 8'd7});
    imem_ack = 1'b1;
    step();
    check("discard_next", {imem_req, imem_addr}, {1'b1, 8'h40});
    repeat (6) step();

    // 5) redirect to 0x10 together with ack and pop
    do_reset(1'b1, 1'b1);
    wait_addr(8'h0C, "reach_0c");
    check("pop_present", {63'd0, inst_valid}, 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h10;
    step();
    redirect_valid = 1'b0;
    check("redir_ack", {inst_valid, imem_req, imem_addr}, {1'b0, 1'b1, 8'h10});
    repeat (6) step();

    // 6) wrap-around from 0xFE, then reset mid-stream
    do_reset(1'b1, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFE;
    step();
    redirect_valid = 1'b0;
    check("wrap_fe", {imem_req, imem_addr}, {1'b1, 8'hFE});
    step();
    check("wrap_ff", {imem_addr, inst_valid, inst_pc}, {8'hFF, 1'b1, 8'hFE});
    step();
    check("wrap_00", {imem_addr, inst_valid, inst_pc}, {8'h00, 1'b1, 8'hFF});
    step();
    check("wrap_pc00", {inst_valid, inst_pc}, {1'b1, 8'h00});
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");

    // 7) randomized traffic
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      imem_ack       = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 31) == 0);
      redirect_pc    = 8'($urandom_range(0, 255));
      step();
    end
    redirect_valid = 1'b0;
    imem_ack       = 1'b1;
    inst_ready     = 1'b1;
    repeat (10) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fetch_unit
